// File: rtl/mccpu_dataflow_pkg.sv
// mccpu_dataflow shared definitions
// opcodes, functs, FSM states, ALU and PC-select codes
package mccpu_dataflow_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd7
  } state_e;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;
  localparam logic [3:0] ALU_SRA = 4'd8;
  localparam logic [3:0] ALU_LUI = 4'd9;

  localparam logic [1:0] PC_INC = 2'd0;
  localparam logic [1:0] PC_JMP = 2'd1;
  localparam logic [1:0] PC_A   = 2'd2;
  localparam logic [1:0] PC_BR  = 2'd3;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_SRA = 6'h03;
  localparam logic [5:0] F_JR  = 6'h08;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_XOR = 6'h26;
  localparam logic [5:0] F_SLT = 6'h2A;

endpackage

// File: rtl/alu.sv
// 32-bit ALU, wrapping arithmetic
// shifts take the amount from a[4:0]
module alu
  import mccpu_dataflow_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  aluc,
  output logic [31:0] y
);
  always_comb begin
    y = '0;
    unique case (aluc)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_SLT: y = {31'b0, $signed(a) < $signed(b)};
      ALU_SLL: y = b << a[4:0];
      ALU_SRL: y = b >> a[4:0];
      ALU_SRA: y = $signed(b) >>> a[4:0];
      ALU_LUI: y = {b[15:0], 16'b0};
      default: y = '0;
    endcase
  end
endmodule

// File: rtl/cla32.sv
// 32-bit carry-lookahead adder
// used for PC+4 and branch target
module cla32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s
);
  logic [31:0] g, p, c;

  always_comb begin
    g = a & b;
    p = a ^ b;
    c = '0;
    c[0] = ci;
    for (int i = 0; i < 31; i++)
      c[i+1] = g[i] | (p[i] & c[i]);
    s = p ^ c;
  end
endmodule

// File: rtl/mccu_fsm.sv
// multicycle control: state register,
// next-state logic and instruction decode
module mccu_fsm
  import mccpu_dataflow_pkg::*;
#(
  parameter int MEM_TIMEOUT = 0,
  parameter int TW          = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [5:0]    op,
  input  logic [5:0]    funct,
  input  logic          mem_ready,
  input  logic          eq,
  input  logic          misalign,
  input  logic [TW-1:0] wcnt,
  output logic [2:0]    state,
  output logic [3:0]    aluc,
  output logic          use_shamt,
  output logic          use_imm,
  output logic          zext,
  output logic          wr_rt,
  output logic          is_load,
  output logic          is_store,
  output logic          is_jal,
  output logic          pc_we,
  output logic [1:0]    pc_sel,
  output logic          rf_we
);
  state_e cur, nxt;
  logic legal, is_j, is_jr, is_br, is_bne, tmo;

  always_ff @(posedge clock or posedge reset)
    if (reset) cur <= S_IF;
    else       cur <= nxt;

  assign state = cur;
  assign tmo = (MEM_TIMEOUT != 0) && !mem_ready
            && (wcnt == TW'(MEM_TIMEOUT - 1));

  always_comb begin
    aluc = ALU_ADD; use_shamt = 1'b0;
    use_imm = 1'b0; zext = 1'b0; wr_rt = 1'b0;
    is_load = 1'b0; is_store = 1'b0;
    is_jal = 1'b0; is_j = 1'b0; is_jr = 1'b0;
    is_br = 1'b0; is_bne = 1'b0; legal = 1'b1;
    unique case (op)
      OP_R: unique case (funct)
        F_ADD: aluc = ALU_ADD;
        F_SUB: aluc = ALU_SUB;
        F_AND: aluc = ALU_AND;
        F_OR:  aluc = ALU_OR;
        F_XOR: aluc = ALU_XOR;
        F_SLT: aluc = ALU_SLT;
        F_SLL: begin aluc = ALU_SLL; use_shamt = 1'b1; end
        F_SRL: begin aluc = ALU_SRL; use_shamt = 1'b1; end
        F_SRA: begin aluc = ALU_SRA; use_shamt = 1'b1; end
        F_JR:  is_jr = 1'b1;
        default: legal = 1'b0;
      endcase
      OP_J:    is_j = 1'b1;
      OP_JAL:  is_jal = 1'b1;
      OP_BEQ:  is_br = 1'b1;
      OP_BNE:  begin is_br = 1'b1; is_bne = 1'b1; end
      OP_ADDI: begin use_imm = 1'b1; wr_rt = 1'b1; end
      OP_ANDI: begin aluc = ALU_AND; use_imm = 1'b1; zext = 1'b1; wr_rt = 1'b1; end
      OP_ORI:  begin aluc = ALU_OR;  use_imm = 1'b1; zext = 1'b1; wr_rt = 1'b1; end
      OP_XORI: begin aluc = ALU_XOR; use_imm = 1'b1; zext = 1'b1; wr_rt = 1'b1; end
      OP_LUI:  begin aluc = ALU_LUI; use_imm = 1'b1; zext = 1'b1; wr_rt = 1'b1; end
      OP_LW:   begin use_imm = 1'b1; wr_rt = 1'b1; is_load = 1'b1; end
      OP_SW:   begin use_imm = 1'b1; is_store = 1'b1; end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    nxt = cur;
    pc_we = 1'b0;
    pc_sel = PC_INC;
    rf_we = 1'b0;
    unique case (cur)
      S_IF:
        if (mem_ready) begin
          nxt = S_ID; pc_we = 1'b1;
        end else if (tmo) nxt = S_TRAP;
      S_ID:
        if (!legal) nxt = S_TRAP;
        else if (is_j || is_jal) begin
          nxt = S_IF; pc_we = 1'b1;
          pc_sel = PC_JMP; rf_we = is_jal;
        end else nxt = S_EX;
      S_EX:
        if (is_jr) begin
          nxt = S_IF; pc_we = 1'b1; pc_sel = PC_A;
        end else if (is_br) begin
          nxt = S_IF; pc_we = eq ^ is_bne; pc_sel = PC_BR;
        end else if (is_load || is_store)
          nxt = misalign ? S_TRAP : S_MEM;
        else nxt = S_WB;
      S_MEM:
        if (mem_ready) nxt = is_store ? S_IF : S_WB;
        else if (tmo) nxt = S_TRAP;
      S_WB: begin rf_we = 1'b1; nxt = S_IF; end
      S_TRAP: nxt = S_TRAP;
      default: nxt = S_TRAP;
    endcase
  end
endmodule

// File: rtl/regfile.sv
// 32x32 register file, two read ports
// r0 is hardwired to zero; clrn clears all
module regfile (
  input  logic        clk,
  input  logic        clrn,
  input  logic [4:0]  rna,
  input  logic [4:0]  rnb,
  output logic [31:0] qa,
  output logic [31:0] qb,
  input  logic        we,
  input  logic [4:0]  wn,
  input  logic [31:0] d
);
  logic [31:0] rf [0:31];

  assign qa = (rna == 5'd0) ? 32'd0 : rf[rna];
  assign qb = (rnb == 5'd0) ? 32'd0 : rf[rnb];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (we && wn != 5'd0) begin
      rf[wn] <= d;
    end
  end
endmodule

// File: rtl/mccpu_dataflow.sv
// multicycle MIPS-subset datapath
// single shared memory port with ready handshake
module mccpu_dataflow
  import mccpu_dataflow_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_TIMEOUT = 0,
  parameter int          TW          = 8
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic [2:0]  state,
  output logic        trap
);
  logic [31:0] ir, a, b, aluout, mdr, pc_r;
  logic [31:0] qa, qb, pc_inc, br_tgt, pc_next;
  logic [31:0] imm_ext, alu_a, alu_b, alu_y, wd, addr_raw;
  logic [TW-1:0] wcnt;
  logic [4:0] wn;
  logic [3:0] aluc;
  logic [1:0] pc_sel;
  logic use_shamt, use_imm, zext, wr_rt;
  logic is_load, is_store, is_jal, pc_we, rf_we, waiting;

  mccu_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT), .TW(TW)) u_fsm (
    .clock(clock), .reset(reset),
    .op(ir[31:26]), .funct(ir[5:0]),
    .mem_ready(mem_ready), .eq(a == b),
    .misalign(alu_y[1:0] != 2'b00), .wcnt(wcnt),
    .state(state), .aluc(aluc),
    .use_shamt(use_shamt), .use_imm(use_imm),
    .zext(zext), .wr_rt(wr_rt),
    .is_load(is_load), .is_store(is_store),
    .is_jal(is_jal), .pc_we(pc_we),
    .pc_sel(pc_sel), .rf_we(rf_we)
  );

  assign imm_ext = zext ? {16'b0, ir[15:0]}
                        : {{16{ir[15]}}, ir[15:0]};
  assign alu_a = use_shamt ? {27'b0, ir[10:6]} : a;
  assign alu_b = use_imm ? imm_ext : b;

  cla32 u_inc (.a(pc_r), .b(32'd4), .ci(1'b0), .s(pc_inc));
  cla32 u_br (
    .a(pc_r), .b({{14{ir[15]}}, ir[15:0], 2'b00}),
    .ci(1'b0), .s(br_tgt)
  );

  alu u_alu (.a(alu_a), .b(alu_b), .aluc(aluc), .y(alu_y));

  // jal writes r31 from ID, where pc already holds the return address
  assign wn = is_jal ? 5'd31 : (wr_rt ? ir[20:16] : ir[15:11]);
  assign wd = is_jal ? pc_r : (is_load ? mdr : aluout);

  regfile u_rf (
    .clk(clock), .clrn(~reset),
    .rna(ir[25:21]), .rnb(ir[20:16]),
    .qa(qa), .qb(qb),
    .we(rf_we), .wn(wn), .d(wd)
  );

  always_comb begin
    pc_next = pc_inc;
    unique case (pc_sel)
      PC_JMP:  pc_next = {pc_r[31:28], ir[25:0], 2'b00};
      PC_A:    pc_next = a;
      PC_BR:   pc_next = aluout;
      default: pc_next = pc_inc;
    endcase
  end

  assign waiting = (state == S_IF || state == S_MEM) && !mem_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_r <= RESET_PC; ir <= '0; a <= '0; b <= '0;
      aluout <= '0; mdr <= '0; wcnt <= '0;
    end else begin
      if (pc_we) pc_r <= pc_next;
      if (state == S_IF && mem_ready) ir <= mem_rdata;
      if (state == S_ID) begin
        a <= qa; b <= qb; aluout <= br_tgt;
      end
      if (state == S_EX) aluout <= alu_y;
      if (state == S_MEM && mem_ready) mdr <= mem_rdata;
      wcnt <= waiting ? wcnt + 1'b1 : '0;
    end
  end

  assign addr_raw  = (state == S_MEM) ? aluout : pc_r;
  assign mem_addr  = {addr_raw[31:2], 2'b00};
  assign mem_req   = ~reset & (state == S_IF || state == S_MEM);
  assign mem_we    = mem_req & (state == S_MEM) & is_store;
  assign mem_wdata = b;
  assign pc        = pc_r;
  assign trap      = (state == S_TRAP);
endmodule

// File: tb/tb_mccpu_dataflow.sv
// directed bench for mccpu_dataflow
// u0: no timeout, wait-state memory; u1: MEM_TIMEOUT=4, never ready
module tb_mccpu_dataflow;
  logic clock = 1'b0;
  logic reset;
  logic clr;
  int checks = 0;
  int failures = 0;
  int dwait = 0;
  int tbw;
  int wr_count;
  int dacc;

  logic        mem_req, mem_we, mem_ready, trap;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic [2:0]  state;

  logic        u1_req, u1_we, u1_trap;
  logic [31:0] u1_addr, u1_wdata, u1_pc;
  logic [2:0]  u1_state;
  logic        u1_ready;
  logic [31:0] u1_rdata;

  logic [31:0] rom [0:255];
  logic [31:0] ram [0:255];
  logic        ram_v [0:255];

  always #5 clock = ~clock;

  mccpu_dataflow u0 (
    .clock(clock), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc(pc), .state(state), .trap(trap)
  );

  mccpu_dataflow #(.MEM_TIMEOUT(4)) u1 (
    .clock(clock), .reset(reset),
    .mem_req(u1_req), .mem_we(u1_we),
    .mem_addr(u1_addr), .mem_wdata(u1_wdata),
    .mem_rdata(u1_rdata), .mem_ready(u1_ready),
    .pc(u1_pc), .state(u1_state), .trap(u1_trap)
  );

  assign u1_ready = 1'b0;
  assign u1_rdata = 32'h0;

  // data accesses see dwait wait states, fetches none
  assign mem_ready = mem_req && (tbw >= ((state == 3'd3) ? dwait : 0));
  assign mem_rdata = ram_v[mem_addr[9:2]] ? ram[mem_addr[9:2]]
                                          : rom[mem_addr[9:2]];

  always @(posedge clock or posedge reset) begin
    if (reset) tbw <= 0;
    else if (mem_req) tbw <= mem_ready ? 0 : tbw + 1;
  end

  always @(posedge clock) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) ram_v[i] <= 1'b0;
      wr_count <= 0;
      dacc <= 0;
    end else begin
      if (mem_req && state == 3'd3) dacc <= dacc + 1;
      if (mem_req && mem_ready && mem_we) begin
        ram[mem_addr[9:2]] <= mem_wdata;
        ram_v[mem_addr[9:2]] <= 1'b1;
        wr_count <= wr_count + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic begin_phase(input int dw);
    reset = 1'b1;
    clr = 1'b1;
    dwait = dw;
    @(posedge clock);
    #1;
    clr = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 32'h0;
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b0;
    clr = 1'b0;
    #1;

    // boot and ALU classes
    begin_phase(0);
    rom[0] = 32'h20010005;
    rom[1] = 32'h20000007;
    rom[2] = 32'h00012022;
    rom[3] = 32'h00042843;
    rom[4] = 32'h30868001;
    rom[5] = 32'h3C071234;
    rom[6] = 32'h0081402A;
    rom[7] = 32'h1000FFFF;
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_state", {29'b0, state}, 32'd0);
    chk("rst_trap", {31'b0, trap}, 32'd0);
    chk("rst_u1_req", {31'b0, u1_req}, 32'd0);
    release_reset();
    chk("boot_req", {31'b0, mem_req}, 32'd1);
    chk("boot_addr", mem_addr, 32'h0);
    chk("u1_req_on", {31'b0, u1_req}, 32'd1);
    step(3);
    chk("addi_wb_state", {29'b0, state}, 32'd4);
    chk("u1_wait3_state", {29'b0, u1_state}, 32'd0);
    chk("u1_wait3_req", {31'b0, u1_req}, 32'd1);
    step(1);
    chk("u1_tmo_state", {29'b0, u1_state}, 32'd7);
    chk("u1_tmo_trap", {31'b0, u1_trap}, 32'd1);
    chk("u1_tmo_req", {31'b0, u1_req}, 32'd0);
    chk("u1_tmo_we", {31'b0, u1_we}, 32'd0);
    chk("u1_tmo_pc", u1_pc, 32'h0);
    chk("u1_tmo_wdata", u1_wdata, 32'h0);
    chk("u1_tmo_addr", u1_addr, 32'h0);
    chk("boot_pc", pc, 32'h4);
    chk("boot_r1", u0.u_rf.rf[1], 32'd5);
    chk("boot_state", {29'b0, state}, 32'd0);
    step(4);
    chk("r0_pc", pc, 32'h8);
    chk("r0_zero", u0.u_rf.rf[0], 32'h0);
    step(4);
    chk("sub_r4", u0.u_rf.rf[4], 32'hFFFF_FFFB);
    step(4);
    chk("sra_r5", u0.u_rf.rf[5], 32'hFFFF_FFFD);
    step(4);
    chk("andi_r6", u0.u_rf.rf[6], 32'h0000_8001);
    step(4);
    chk("lui_r7", u0.u_rf.rf[7], 32'h1234_0000);
    step(4);
    chk("slt_r8", u0.u_rf.rf[8], 32'h1);
    chk("slt_pc", pc, 32'h1C);
    step(1);
    chk("beq_id_pc", pc, 32'h20);
    chk("beq_id_state", {29'b0, state}, 32'd1);
    step(2);
    chk("beq_loop1_pc", pc, 32'h1C);
    chk("beq_loop1_state", {29'b0, state}, 32'd0);
    step(3);
    chk("beq_loop2_pc", pc, 32'h1C);

    // store/load with 3 data wait states
    begin_phase(3);
    rom[0] = 32'h20010005;
    rom[1] = 32'hAC010080;
    rom[2] = 32'h8C020080;
    rom[3] = 32'h1422FFFF;
    rom[4] = 32'h1021FFFF;
    release_reset();
    step(4);
    chk("ls_addi_pc", pc, 32'h4);
    step(3);
    chk("sw_addr", mem_addr, 32'h80);
    chk("sw_wdata", mem_wdata, 32'd5);
    chk("sw_we", {31'b0, mem_we}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("sw_wait_req", {28'b0, state, mem_req}, {28'b0, 3'd3, 1'b1});
      step(1);
    end
    chk("sw_done_state", {29'b0, state}, 32'd0);
    chk("sw_done_pc", pc, 32'h8);
    chk("sw_wr_count", wr_count, 32'd1);
    chk("sw_mem80", ram[32], 32'd5);
    step(7);
    chk("lw_wb_state", {29'b0, state}, 32'd4);
    step(1);
    chk("lw_done_pc", pc, 32'hC);
    chk("lw_r2", u0.u_rf.rf[2], 32'd5);
    step(3);
    chk("bne_nt_pc", pc, 32'h10);
    chk("bne_nt_state", {29'b0, state}, 32'd0);
    step(3);
    chk("beq_self_pc", pc, 32'h10);

    // jal, then illegal opcode at the target
    begin_phase(0);
    rom[0]  = 32'h0C000040;
    rom[64] = 32'hFC000000;
    release_reset();
    step(2);
    chk("jal_pc", pc, 32'h100);
    chk("jal_r31", u0.u_rf.rf[31], 32'h4);
    chk("jal_state", {29'b0, state}, 32'd0);
    step(1);
    chk("ill_id_pc", pc, 32'h104);
    step(1);
    chk("ill_state", {29'b0, state}, 32'd7);
    chk("ill_trap", {31'b0, trap}, 32'd1);
    chk("ill_req", {31'b0, mem_req}, 32'd0);
    chk("ill_r31", u0.u_rf.rf[31], 32'h4);
    step(3);
    chk("ill_pc_frozen", pc, 32'h104);
    chk("ill_req_stays", {31'b0, mem_req}, 32'd0);

    // misaligned load
    begin_phase(0);
    rom[0] = 32'h20030009;
    rom[1] = 32'h8C030006;
    release_reset();
    step(4);
    chk("mis_r3_pre", u0.u_rf.rf[3], 32'd9);
    step(3);
    chk("mis_state", {29'b0, state}, 32'd7);
    chk("mis_trap", {31'b0, trap}, 32'd1);
    chk("mis_dacc", dacc, 32'd0);
    chk("mis_r3", u0.u_rf.rf[3], 32'd9);
    step(2);
    chk("mis_dacc_late", dacc, 32'd0);

    // async reset during a store wait
    begin_phase(3);
    rom[0] = 32'h20010005;
    rom[1] = 32'hAC010080;
    release_reset();
    step(7);
    chk("ar_mem_state", {28'b0, state, mem_req}, {28'b0, 3'd3, 1'b1});
    step(1);
    #3;
    reset = 1'b1;
    #1;
    chk("ar_req", {31'b0, mem_req}, 32'd0);
    chk("ar_we", {31'b0, mem_we}, 32'd0);
    chk("ar_pc", pc, 32'h0);
    chk("ar_state", {29'b0, state}, 32'd0);
    step(2);
    chk("ar_no_write", wr_count, 32'd0);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
